// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared instruction/data memory port.
// Port 0 = instruction fetch, port 1 = data memory. A two-state FSM sequences
// each access, drives the address/write-data mux select and aborts accesses
// the memory does not answer within TIMEOUT busy cycles.
module mem_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_0,
    input  logic [31:0] addr_0,
    input  logic        we_0,
    input  logic [31:0] wdata_0,
    input  logic        req_1,
    input  logic [31:0] addr_1,
    input  logic        we_1,
    input  logic [31:0] wdata_1,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        done_0,
    output logic        done_1,
    output logic        err,
    output logic        stall_0,
    output logic        stall_1
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state_q, state_d;
    logic            sel_q, sel_d;
    logic            last_q, last_d;
    logic [CW-1:0]   tcnt_q, tcnt_d;

    logic            busy, timeout, complete;
    logic            r0, r1, winner;

    assign busy     = (state_q == BUSY);
    assign timeout  = (tcnt_q == TLAST);
    assign complete = busy & (mem_ready | timeout);

    // Completion, abort and stall indications back to the pipeline
    assign done_0  = complete & ~sel_q;
    assign done_1  = complete &  sel_q;
    assign err     = busy & timeout & ~mem_ready;
    assign stall_0 = req_0 & ~done_0;
    assign stall_1 = req_1 & ~done_1;

    // Memory-side muxes, steered only by the registered select
    assign sel       = sel_q;
    assign mem_req   = busy;
    assign mem_addr  = sel_q ? addr_1  : addr_0;
    assign mem_wdata = sel_q ? wdata_1 : wdata_0;
    assign mem_we    = (sel_q ? we_1 : we_0) & busy;
    assign rdata     = mem_rdata;

    // Next-state logic: arbitrate in IDLE and on the completion cycle, where
    // the completing port is masked so the other port gets the next slot
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        tcnt_d  = tcnt_q;
        r0      = req_0;
        r1      = req_1;
        if (busy) begin
            r0 = req_0 &  sel_q;
            r1 = req_1 & ~sel_q;
        end
        // On a tie the port not granted last wins; otherwise the lone requester
        winner = (r0 & r1) ? ~last_q : r1;
        case (state_q)
            IDLE: begin
                if (r0 | r1) begin
                    state_d = BUSY;
                    sel_d   = winner;
                    tcnt_d  = '0;
                end
            end
            BUSY: begin
                if (complete) begin
                    last_d = sel_q;
                    if (r0 | r1) begin
                        sel_d  = winner;
                        tcnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tcnt_d = tcnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any access in flight and favours port 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            tcnt_q  <= tcnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1ns after the rising edge,
// outputs are checked 1ns later, well clear of the next edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_0, req_1, we_0, we_1, mem_ready;
    logic [31:0] addr_0, addr_1, wdata_0, wdata_1, mem_rdata;
    logic        mem_req, mem_we, sel, done_0, done_1, err, stall_0, stall_1;
    logic [31:0] mem_addr, mem_wdata, rdata;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .addr_0(addr_0), .we_0(we_0), .wdata_0(wdata_0),
        .req_1(req_1), .addr_1(addr_1), .we_1(we_1), .wdata_1(wdata_1),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .sel(sel), .rdata(rdata),
        .done_0(done_0), .done_1(done_1), .err(err),
        .stall_0(stall_0), .stall_1(stall_1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_0 = 0; req_1 = 0; we_0 = 0; we_1 = 0; mem_ready = 0;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        addr_0 = 0; addr_1 = 0; wdata_0 = 0; wdata_1 = 0; mem_rdata = 0;
        do_reset();
        cyc();

        // ---- reset state, stall follows req while reset holds ----
        rst = 1'b1; req_0 = 1'b1;
        #1;
        check("rst_memreq", mem_req, 0);
        check("rst_memwe", mem_we, 0);
        check("rst_sel", sel, 0);
        check("rst_done0", done_0, 0);
        check("rst_err", err, 0);
        check("rst_stall0", stall_0, 1);
        cyc();
        rst = 1'b0; req_0 = 1'b0;

        // ---- single port-0 read, memory answers in first BUSY cycle ----
        cyc();
        req_0 = 1; addr_0 = 32'h0000_0040; mem_ready = 1; mem_rdata = 32'h1234_5678;
        #1;
        check("t1_idle_memreq", mem_req, 0);
        check("t1_idle_done0", done_0, 0);   // mem_ready ignored outside BUSY
        cyc();
        #1;
        check("t1_memreq", mem_req, 1);
        check("t1_addr", mem_addr, 32'h40);
        check("t1_done0", done_0, 1);
        check("t1_rdata", rdata, 32'h1234_5678);
        check("t1_sel", sel, 0);
        check("t1_stall0", stall_0, 0);
        cyc();
        req_0 = 0; mem_ready = 0;
        #1;
        check("t1_back_idle", mem_req, 0);

        // ---- tie after reset, latency 2: port 0 then port 1 without bubble ----
        do_reset();
        req_0 = 1; req_1 = 1; addr_0 = 32'h100; addr_1 = 32'h2000;
        #1;
        check("t2_idle", mem_req, 0);
        cyc();
        #1;
        check("t2_b1_sel", sel, 0);
        check("t2_b1_done0", done_0, 0);
        check("t2_b1_stall1", stall_1, 1);
        cyc();
        mem_ready = 1;
        #1;
        check("t2_b2_done0", done_0, 1);
        check("t2_b2_done1", done_1, 0);
        cyc();
        req_0 = 0; mem_ready = 0;
        #1;
        check("t2_nobubble", mem_req, 1);
        check("t2_sel1", sel, 1);
        check("t2_c1_done1", done_1, 0);
        cyc();
        mem_ready = 1;
        #1;
        check("t2_c2_done1", done_1, 1);
        check("t2_c2_addr", mem_addr, 32'h2000);
        cyc();
        req_0 = 1; req_1 = 1; mem_ready = 0;   // next tie, from IDLE
        #1;
        check("t2_d_idle", mem_req, 0);
        cyc();
        mem_ready = 1;
        #1;
        check("t2_rr_sel0", sel, 0);
        check("t2_rr_done0", done_0, 1);
        cyc();
        req_0 = 0;
        #1;
        check("t2_f_sel1", sel, 1);
        check("t2_f_done1", done_1, 1);
        cyc();
        req_1 = 0; mem_ready = 0;
        #1;
        check("t2_g_idle", mem_req, 0);

        // ---- port-1 write ----
        cyc();
        req_1 = 1; we_1 = 1; addr_1 = 32'h1000_0000; wdata_1 = 32'hDEAD_BEEF;
        #1;
        check("t3_idle_we", mem_we, 0);
        check("t3_idle_stall1", stall_1, 1);
        cyc();
        #1;
        check("t3_we", mem_we, 1);
        check("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("t3_addr", mem_addr, 32'h1000_0000);
        check("t3_sel", sel, 1);
        check("t3_stall1", stall_1, 1);
        cyc();
        mem_ready = 1;
        #1;
        check("t3_done1", done_1, 1);
        check("t3_stall1_done", stall_1, 0);
        cyc();
        req_1 = 0; we_1 = 0; mem_ready = 0;
        #1;
        check("t3_we_idle", mem_we, 0);
        check("t3_memreq_idle", mem_req, 0);

        // ---- timeout on port 0, then port 1 completes exactly at the limit ----
        cyc();
        req_0 = 1; req_1 = 1; addr_1 = 32'h3000;
        #1;
        check("t4_idle", mem_req, 0);
        cyc();
        for (int b = 1; b <= 16; b++) begin
            #1;
            if (b < 16) begin
                check("t4_p0_err_low", err, 0);
                check("t4_p0_done_low", done_0, 0);
            end else begin
                check("t4_p0_err", err, 1);
                check("t4_p0_done", done_0, 1);
            end
            cyc();
        end
        req_0 = 0;
        for (int b = 1; b <= 16; b++) begin
            mem_ready = (b == 16);
            #1;
            if (b == 1) check("t4_p1_granted", sel, 1);
            check("t4_p1_memreq", mem_req, 1);
            check("t4_p1_err", err, 0);
            check("t4_p1_done", done_1, (b == 16) ? 1 : 0);
            cyc();
        end
        req_1 = 0; mem_ready = 0;
        #1;
        check("t4_idle_after", mem_req, 0);

        // ---- reset in the 2nd BUSY cycle ----
        do_reset();
        req_1 = 1;
        cyc();
        #1;
        check("t5_b1_sel", sel, 1);
        cyc();
        rst = 1;
        #1;
        check("t5_b2_busy", mem_req, 1);
        cyc();
        rst = 0; req_0 = 1; req_1 = 1;
        #1;
        check("t5_memreq", mem_req, 0);
        check("t5_sel", sel, 0);
        check("t5_done1", done_1, 0);
        check("t5_err", err, 0);
        cyc();
        mem_ready = 1;
        #1;
        check("t5_tie_sel0", sel, 0);
        check("t5_tie_done0", done_0, 1);
        cyc();
        req_0 = 0;
        #1;
        check("t5_p1_done1", done_1, 1);
        cyc();
        req_1 = 0; mem_ready = 0;
        #1;
        check("t5_idle", mem_req, 0);

        // ---- continuous port 0: one bubble per access ----
        cyc();
        req_0 = 1; mem_ready = 1;
        #1;
        check("t6_first_idle", mem_req, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            #1;
            check("t6_busy_memreq", mem_req, 1);
            check("t6_busy_done0", done_0, 1);
            cyc();
            #1;
            check("t6_bubble_memreq", mem_req, 0);
            check("t6_bubble_done0", done_0, 0);
        end
        mem_ready = 0;
        cyc();
        req_1 = 1;                            // arrives mid-transaction
        #1;
        check("t6_mid_done0", done_0, 0);
        check("t6_mid_stall1", stall_1, 1);
        cyc();
        mem_ready = 1;
        #1;
        check("t6_done0", done_0, 1);
        cyc();
        req_0 = 0;
        #1;
        check("t6_p1_nobubble", mem_req, 1);
        check("t6_p1_sel", sel, 1);
        check("t6_p1_done1", done_1, 1);
        cyc();
        req_1 = 0; mem_ready = 0;
        #1;
        check("t6_end_idle", mem_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // hard stop in case the stimulus ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog: sim time %0t exceeded limit", $time);
        $fatal(1);
    end

endmodule
